// File: rtl/clk_rst_seq_ctrl.sv
// Per-domain clock/reset sequencer with a small memory-mapped register file.
// Each domain enables its clock first and releases reset SEQ_DLY cycles later; power-down reverses the order.

module clk_rst_seq_dom #(
  parameter int   SEQ_DLY      = 8,
  parameter int   LOCK_TIMEOUT = 1024,
  parameter logic ON_RST       = 1'b0
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       ctrl_we_i,
  input  logic       stat_we_i,
  input  logic       wr_on_i,
  input  logic       wr_wait_i,
  input  logic       wr_to_i,
  input  logic       pll_locked_i,
  output logic [1:0] ctrl_o,
  output logic [3:0] stat_o,
  output logic       clk_en_o,
  output logic       rst_no,
  output logic       to_o
);
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LT_MAX  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SEQ_MAX = CW'(SEQ_DLY - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_CLK_ON = 2'b01,
    S_RST_ON = 2'b10,
    S_RUN    = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          on_q, on_d, wait_q, wait_d, to_q, to_d;
  logic          clk_en_q, rst_n_q;
  logic          hw_timeout;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hw_timeout = 1'b0;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (on_q) state_d = S_CLK_ON;
      end
      S_CLK_ON: begin
        cnt_d = (cnt_q == LT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (!on_q) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q >= SEQ_MAX && (!wait_q || pll_locked_i)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (wait_q && cnt_q == LT_MAX) begin
          state_d    = S_OFF;
          cnt_d      = '0;
          hw_timeout = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!on_q) state_d = S_RST_ON;
      end
      S_RST_ON: begin
        // Power-down drains for SEQ_DLY cycles whatever ON does meanwhile
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= SEQ_MAX) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Hardware clear of ON and set of TO take priority over a same-cycle software write
  always_comb begin
    on_d   = on_q;
    wait_d = wait_q;
    to_d   = to_q;
    if (ctrl_we_i) begin
      on_d   = wr_on_i;
      wait_d = wr_wait_i;
    end
    if (stat_we_i && wr_to_i) to_d = 1'b0;
    if (hw_timeout) begin
      on_d = 1'b0;
      to_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      on_q     <= ON_RST;
      wait_q   <= 1'b1;
      to_q     <= 1'b0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      on_q     <= on_d;
      wait_q   <= wait_d;
      to_q     <= to_d;
      clk_en_q <= (state_d != S_OFF);
      rst_n_q  <= (state_d == S_RUN);
    end
  end

  assign ctrl_o   = {wait_q, on_q};
  assign stat_o   = {to_q, pll_locked_i, state_q};
  assign clk_en_o = clk_en_q;
  assign rst_no   = rst_n_q;
  assign to_o     = to_q;
endmodule

module clk_rst_seq_ctrl #(
  parameter int                 NUM_DOM      = 4,
  parameter int                 SEQ_DLY      = 8,
  parameter int                 LOCK_TIMEOUT = 1024,
  parameter logic [NUM_DOM-1:0] RST_ON       = '0,
  localparam int                ADDR_WIDTH   = 12,
  localparam int                DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_waddr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [3:0]            mem_wstrb_i,
  output logic [1:0]            mem_wresp_o,
  input  logic                  mem_re_i,
  input  logic [ADDR_WIDTH-1:0] mem_raddr_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic [1:0]            mem_rresp_o,
  input  logic [NUM_DOM-1:0]    pll_locked_i,
  output logic [NUM_DOM-1:0]    clk_en_o,
  output logic [NUM_DOM-1:0]    rst_no,
  output logic                  irq_o
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [7:0]                 wdom, rdom;
  logic                       wmap, rmap;
  logic [NUM_DOM-1:0]         ctrl_we, stat_we, to_flag;
  logic [NUM_DOM-1:0][1:0]    dom_ctrl;
  logic [NUM_DOM-1:0][3:0]    dom_stat;
  logic [DATA_WIDTH-1:0]      rdata_sel;
  logic                       unused_wbits;

  assign wdom = mem_waddr_i[11:4];
  assign rdom = mem_raddr_i[11:4];
  assign wmap = (32'(wdom) < NUM_DOM) && (mem_waddr_i[3:0] == 4'h0 || mem_waddr_i[3:0] == 4'h4);
  assign rmap = (32'(rdom) < NUM_DOM) && (mem_raddr_i[3:0] == 4'h0 || mem_raddr_i[3:0] == 4'h4);

  assign unused_wbits = ^{mem_wdata_i[31:4], mem_wdata_i[2], mem_wstrb_i[3:1]};

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    assign ctrl_we[d] = mem_we_i && wmap && mem_wstrb_i[0] && wdom == 8'(d) && !mem_waddr_i[2];
    assign stat_we[d] = mem_we_i && wmap && mem_wstrb_i[0] && wdom == 8'(d) &&  mem_waddr_i[2];

    clk_rst_seq_dom #(
      .SEQ_DLY      (SEQ_DLY),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .ON_RST       (RST_ON[d])
    ) u_dom (
      .clk_i        (clk_i),
      .arst_ni      (arst_ni),
      .ctrl_we_i    (ctrl_we[d]),
      .stat_we_i    (stat_we[d]),
      .wr_on_i      (mem_wdata_i[0]),
      .wr_wait_i    (mem_wdata_i[1]),
      .wr_to_i      (mem_wdata_i[3]),
      .pll_locked_i (pll_locked_i[d]),
      .ctrl_o       (dom_ctrl[d]),
      .stat_o       (dom_stat[d]),
      .clk_en_o     (clk_en_o[d]),
      .rst_no       (rst_no[d]),
      .to_o         (to_flag[d])
    );
  end

  always_comb begin
    rdata_sel = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      if (rdom == 8'(d))
        rdata_sel = mem_raddr_i[2] ? {28'b0, dom_stat[d]} : {30'b0, dom_ctrl[d]};
    end
  end

  assign mem_wresp_o = (mem_we_i && wmap) ? RESP_OKAY : RESP_SLVERR;
  assign mem_rresp_o = (mem_re_i && rmap) ? RESP_OKAY : RESP_SLVERR;
  assign mem_rdata_o = (mem_re_i && rmap) ? rdata_sel : '0;
  assign irq_o       = |to_flag;
endmodule

// File: doc/clk_rst_seq_ctrl.md
CLK_RST_SEQ_CTRL -- requirements
Module: clk_rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOM, default 4, number of clock/reset domains (1..8).
REQ-002 SHALL have parameter SEQ_DLY, default 8, cycles between clock enable and reset release (and the reverse); range 1..255.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024, max cycles in CLK_ON before timeout; must be > SEQ_DLY.
REQ-004 SHALL have parameter RST_ON, default '0, NUM_DOM-bit reset value of the per-domain ON bits.
REQ-005 SHALL have ADDR_WIDTH=12 and DATA_WIDTH=32 as fixed localparams.
REQ-006 arst_ni  in  1  asynchronous active-low reset.
REQ-007 clk_i  in  1  clock.
REQ-008 mem_we_i / mem_waddr_i[11:0] / mem_wdata_i[31:0] / mem_wstrb_i[3:0]  in  write request; mem_wresp_o[1:0]  out  00 OKAY, 10 SLVERR.
REQ-009 mem_re_i / mem_raddr_i[11:0]  in  read request; mem_rdata_o[31:0], mem_rresp_o[1:0]  out.
REQ-010 pll_locked_i  in  NUM_DOM  per-domain PLL lock status.
REQ-011 clk_en_o  out  NUM_DOM  per-domain clock enable.
REQ-012 rst_no  out  NUM_DOM  per-domain active-low reset.
REQ-013 irq_o  out  1  OR of all TO sticky flags.

Function
REQ-014 Register map, domain d: CTRL at 0x010*d (bit0 ON RW, bit1 WAIT_LOCK RW reset 1, bits 31:2 read 0); STAT at 0x010*d+0x4 (bits1:0 state RO, bit2 pll_locked_i[d] RO, bit3 TO W1C).
REQ-015 Address is mapped only if addr[11:4] < NUM_DOM and addr[3:0] is 0x0 or 0x4; all other addresses SHALL return SLVERR and rdata 0.
REQ-016 Write and read responses SHALL be combinational in the request cycle; register updates SHALL take effect on the next clk_i edge.
REQ-017 Writes SHALL update bits 7:0 only when mem_wstrb_i[0]=1; wstrb[0]=0 to a mapped address SHALL be OKAY with no change.
REQ-018 When neither we nor re is asserted, resp outputs SHALL be 10 and rdata 0.
REQ-019 Each domain SHALL run an independent FSM, state encoding OFF=00, CLK_ON=01, RST_ON=10, RUN=11.
REQ-020 Outputs per state: OFF clk_en=0 rst_n=0; CLK_ON clk_en=1 rst_n=0; RUN clk_en=1 rst_n=1; RST_ON clk_en=1 rst_n=0; outputs SHALL be registered (state-decoded from flops).
REQ-021 OFF -> CLK_ON when ON=1; counter cleared on entry.
REQ-022 In CLK_ON the counter SHALL increment each cycle, saturating at LOCK_TIMEOUT-1.
REQ-023 CLK_ON -> RUN when cnt >= SEQ_DLY-1 and (WAIT_LOCK=0 or pll_locked_i[d]=1); rst_no therefore rises exactly SEQ_DLY cycles after clk_en_o when unconstrained.
REQ-024 CLK_ON -> OFF when ON=0 (reset never released, no delay).
REQ-025 CLK_ON with WAIT_LOCK=1, lock absent at cnt=LOCK_TIMEOUT-1 -> OFF, set TO, clear ON by hardware.
REQ-026 RUN -> RST_ON when ON=0; RST_ON holds SEQ_DLY cycles, then -> OFF regardless of ON; if ON=1 at that point, OFF -> CLK_ON on the following cycle.
REQ-027 Loss of pll_locked_i in RUN SHALL not change state.
REQ-028 Simultaneous software write and hardware event in one cycle: hardware clear of ON and hardware set of TO SHALL win.
REQ-029 Counter width SHALL be $clog2(LOCK_TIMEOUT); no wrap-around is permitted.

Reset
REQ-030 On arst_ni low: all FSMs OFF, counters 0, clk_en_o=0, rst_no=0, TO=0, WAIT_LOCK=1, ON=RST_ON, irq_o=0, all asynchronously.
REQ-031 After reset release, domains with RST_ON[d]=1 SHALL begin the power-up sequence on the first clk_i edge.
REQ-032 Reset asserted mid-sequence SHALL immediately force the domain to OFF outputs.

Verification
REQ-033 Write 0x1 to 0x000 (WAIT_LOCK=0), SEQ_DLY=8 -> clk_en_o[0]=1 one cycle later, rst_no[0]=1 eight cycles after that, STAT reads 0x3.
REQ-034 Write 0x3 to 0x010, pll_locked_i[1]=0 for 1024 cycles -> clk_en_o[1]=0, STAT[1] bit3=1, CTRL[1] reads 0x2, irq_o=1; write 0x8 to 0x014 -> irq_o=0.
REQ-035 Domain 2 in RUN, write 0x0 to 0x020 -> rst_no[2]=0 next cycle, clk_en_o[2]=0 eight cycles later; rewrite 0x1 during RST_ON -> returns to CLK_ON after reaching OFF.
REQ-036 Read 0x040 (NUM_DOM=4), 0x008, write 0x002 -> resp 10, rdata 0; write with wstrb=0 to 0x000 -> resp 00, CTRL unchanged.
REQ-037 RST_ON=4'b0011 -> after reset deassertion, domains 0,1 reach RUN; assert arst_ni low mid-CLK_ON -> clk_en_o=0 asynchronously.
